// File: rtl/mem_req_scheduler.sv
// Single-port data-memory request scheduler: arbitrates spec loads, load re-executes
// and stores onto one dmem port, with starvation promotion and order-based squash.
module mem_req_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req_valid,
  input  logic [95:0]  req_addr,
  input  logic [11:0]  req_rmask,
  input  logic [3:0]   req_wmask,
  input  logic [31:0]  req_wdata,
  input  logic [191:0] req_order,
  output logic [2:0]   grant,
  output logic [2:0]   resp_valid,
  output logic [31:0]  resp_rdata,
  output logic [31:0]  dmem_addr,
  output logic [3:0]   dmem_rmask,
  output logic [3:0]   dmem_wmask,
  output logic [31:0]  dmem_wdata,
  input  logic [31:0]  dmem_rdata,
  input  logic         dmem_resp,
  input  logic         flush_pipeline,
  input  logic [63:0]  flush_order,
  output logic         busy
);

  localparam int CW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_starve_cnt;
  logic [CW-1:0]   w_starve_next;

  logic [2:0]      r_owner;
  logic [31:0]     r_addr;
  logic [3:0]      r_rmask;
  logic [3:0]      r_wmask;
  logic [31:0]     r_wdata;
  logic [63:0]     r_order;
  logic [2:0]      r_resp_valid;
  logic [31:0]     r_resp_rdata;

  logic [2:0]      w_elig;
  logic [2:0]      w_win;
  logic            w_starved;
  logic            w_owner_squash;
  logic            w_resp_fire;
  logic [31:0]     w_win_addr;
  logic [3:0]      w_win_rmask;
  logic [3:0]      w_win_wmask;
  logic [31:0]     w_win_wdata;
  logic [63:0]     w_win_order;
  logic            w_unused;

  // The store's read mask has no meaning and is dropped.
  assign w_unused = &{1'b0, req_rmask[11:8]};

  // Loads whose order is younger than an active flush cannot be accepted; stores always can.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_elig
      logic w_squash_req;
      assign w_squash_req = flush_pipeline && (gi != 2) &&
                            (req_order[64*gi +: 64] > flush_order);
      assign w_elig[gi]   = req_valid[gi] && !w_squash_req;
    end
  endgenerate

  assign w_starved = (r_starve_cnt >= CW'(STARVE_LIMIT));

  always_comb begin
    w_win = 3'b000;
    if (r_state == S_IDLE && !rst) begin
      if (w_starved && w_elig[0])  w_win = 3'b001;
      else if (w_elig[1])          w_win = 3'b010;
      else if (w_elig[2])          w_win = 3'b100;
      else if (w_elig[0])          w_win = 3'b001;
    end
  end

  always_comb begin
    w_win_addr  = 32'd0;
    w_win_rmask = 4'd0;
    w_win_wmask = 4'd0;
    w_win_wdata = 32'd0;
    w_win_order = 64'd0;
    if (w_win[0]) begin
      w_win_addr  = req_addr[31:0];
      w_win_rmask = req_rmask[3:0];
      w_win_order = req_order[63:0];
    end else if (w_win[1]) begin
      w_win_addr  = req_addr[63:32];
      w_win_rmask = req_rmask[7:4];
      w_win_order = req_order[127:64];
    end else if (w_win[2]) begin
      w_win_addr  = req_addr[95:64];
      w_win_wmask = req_wmask;
      w_win_wdata = req_wdata;
      w_win_order = req_order[191:128];
    end
  end

  assign w_owner_squash = flush_pipeline && !r_owner[2] && (r_order > flush_order);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_resp_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_win) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // A squash landing with the completion still suppresses the response.
        if (dmem_resp) begin
          w_state_next = S_IDLE;
          w_resp_fire  = !w_owner_squash;
        end else if (w_owner_squash) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dmem_resp) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (w_win[0])
      w_starve_next = '0;
    else if ((w_win[1] || w_win[2]) && req_valid[0] && (r_starve_cnt != {CW{1'b1}}))
      w_starve_next = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_owner      <= 3'b000;
      r_addr       <= 32'd0;
      r_rmask      <= 4'd0;
      r_wmask      <= 4'd0;
      r_wdata      <= 32'd0;
      r_order      <= 64'd0;
      r_resp_valid <= 3'b000;
      r_resp_rdata <= 32'd0;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_resp_valid <= w_resp_fire ? r_owner : 3'b000;
      r_resp_rdata <= (w_resp_fire && !r_owner[2]) ? dmem_rdata : 32'd0;
      if (|w_win) begin
        r_owner <= w_win;
        r_addr  <= w_win_addr;
        r_rmask <= w_win_rmask;
        r_wmask <= w_win_wmask;
        r_wdata <= w_win_wdata;
        r_order <= w_win_order;
      end
    end
  end

  always_comb begin
    if (r_state == S_IDLE) begin
      dmem_addr  = w_win_addr;
      dmem_rmask = w_win_rmask;
      dmem_wmask = w_win_wmask;
      dmem_wdata = w_win_wdata;
    end else begin
      dmem_addr  = r_addr;
      dmem_rmask = r_rmask;
      dmem_wmask = r_wmask;
      dmem_wdata = r_wdata;
    end
  end

  assign grant      = w_win;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: table of idle arbitration vectors plus
// hand-written sequences for completion, starvation, squash and reset.
module tb_mem_req_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid;
  logic [95:0]  req_addr;
  logic [11:0]  req_rmask;
  logic [3:0]   req_wmask;
  logic [31:0]  req_wdata;
  logic [191:0] req_order;
  logic [2:0]   grant;
  logic [2:0]   resp_valid;
  logic [31:0]  resp_rdata;
  logic [31:0]  dmem_addr;
  logic [3:0]   dmem_rmask;
  logic [3:0]   dmem_wmask;
  logic [31:0]  dmem_wdata;
  logic [31:0]  dmem_rdata;
  logic         dmem_resp;
  logic         flush_pipeline;
  logic [63:0]  flush_order;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_req_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_rmask(req_rmask),
    .req_wmask(req_wmask), .req_wdata(req_wdata), .req_order(req_order),
    .grant(grant), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .flush_pipeline(flush_pipeline), .flush_order(flush_order), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic        flush;
    logic [63:0] forder;
    logic [2:0]  exp_grant;
    logic [31:0] exp_addr;
    logic [3:0]  exp_rmask;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_valid      = 3'b000;
    dmem_resp      = 1'b0;
    flush_pipeline = 1'b0;
    flush_order    = 64'd0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    // Orders: spec=30, load=20, store=25.
    req_addr   = {32'h3000, 32'h2000, 32'h1000};
    req_rmask  = {4'h1, 4'h3, 4'hF};
    req_wmask  = 4'hC;
    req_wdata  = 32'hCAFE_F00D;
    req_order  = {64'd25, 64'd20, 64'd30};
    dmem_rdata = 32'd0;

    vecs[0]  = '{3'b111, 1'b0, 64'd0,  3'b010, 32'h2000, 4'h3, 4'h0, 32'h0};
    vecs[1]  = '{3'b101, 1'b0, 64'd0,  3'b100, 32'h3000, 4'h0, 4'hC, 32'hCAFE_F00D};
    vecs[2]  = '{3'b001, 1'b0, 64'd0,  3'b001, 32'h1000, 4'hF, 4'h0, 32'h0};
    vecs[3]  = '{3'b000, 1'b0, 64'd0,  3'b000, 32'h0,    4'h0, 4'h0, 32'h0};
    vecs[4]  = '{3'b111, 1'b1, 64'd25, 3'b010, 32'h2000, 4'h3, 4'h0, 32'h0};
    vecs[5]  = '{3'b011, 1'b1, 64'd10, 3'b000, 32'h0,    4'h0, 4'h0, 32'h0};
    vecs[6]  = '{3'b111, 1'b1, 64'd10, 3'b100, 32'h3000, 4'h0, 4'hC, 32'hCAFE_F00D};
    vecs[7]  = '{3'b011, 1'b1, 64'd20, 3'b010, 32'h2000, 4'h3, 4'h0, 32'h0};
    vecs[8]  = '{3'b001, 1'b1, 64'd29, 3'b000, 32'h0,    4'h0, 4'h0, 32'h0};
    vecs[9]  = '{3'b001, 1'b1, 64'd30, 3'b001, 32'h1000, 4'hF, 4'h0, 32'h0};
    vecs[10] = '{3'b011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 32'h2000, 4'h3, 4'h0, 32'h0};

    // Reset state, with requests present while rst is held.
    rst = 1'b1; req_valid = 3'b111; dmem_resp = 1'b0;
    flush_pipeline = 1'b0; flush_order = 64'd0;
    step();
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_dmem_addr", 64'(dmem_addr), 64'd0);
    chk("rst_dmem_wmask", 64'(dmem_wmask), 64'd0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      req_valid      = vecs[i].valid;
      flush_pipeline = vecs[i].flush;
      flush_order    = vecs[i].forder;
      #1;
      chk($sformatf("v%0d_grant", i), 64'(grant), 64'(vecs[i].exp_grant));
      chk($sformatf("v%0d_addr", i), 64'(dmem_addr), 64'(vecs[i].exp_addr));
      chk($sformatf("v%0d_rmask", i), 64'(dmem_rmask), 64'(vecs[i].exp_rmask));
      chk($sformatf("v%0d_wmask", i), 64'(dmem_wmask), 64'(vecs[i].exp_wmask));
      chk($sformatf("v%0d_wdata", i), 64'(dmem_wdata), 64'(vecs[i].exp_wdata));
      step();
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].exp_grant != 3'b000));
      $display("vector %0d valid=%b flush=%0d forder=%0h grant_exp=%b", i,
               vecs[i].valid, vecs[i].flush, vecs[i].forder, vecs[i].exp_grant);
    end

    // Load completes after 3 wait cycles; store granted in the response cycle.
    do_reset();
    req_valid = 3'b010;
    #1 chk("b2b_load_grant", 64'(grant), 64'b010);
    step();
    req_valid = 3'b111;
    chk("b2b_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("b2b_wait%0d_grant", k), 64'(grant), 64'd0);
      chk($sformatf("b2b_wait%0d_addr", k), 64'(dmem_addr), 64'h2000);
      step();
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_resp = 1'b0; req_valid = 3'b100;
    chk("b2b_resp_valid", 64'(resp_valid), 64'b010);
    chk("b2b_resp_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
    #1;
    chk("b2b_store_grant", 64'(grant), 64'b100);
    chk("b2b_store_addr", 64'(dmem_addr), 64'h3000);
    step();
    req_valid = 3'b000;
    chk("b2b_resp_pulse", 64'(resp_valid), 64'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h5555_5555;
    step();
    dmem_resp = 1'b0;
    chk("b2b_store_resp", 64'(resp_valid), 64'b100);
    chk("b2b_store_rdata", 64'(resp_rdata), 64'd0);
    $display("sequence back-to-back load/store done");

    // Starvation: four load grants with spec waiting, then spec wins, then load again.
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("starve_grant%0d", k), 64'(grant), (k == 4) ? 64'b001 : 64'b010);
      step();
      dmem_resp = 1'b1;
      step();
      dmem_resp = 1'b0;
    end
    $display("sequence starvation done");

    // Spec squashed in WAIT, then drained.
    do_reset();
    req_order[63:0] = 64'd20;
    req_valid = 3'b001;
    #1 chk("squash_grant", 64'(grant), 64'b001);
    step();
    req_valid = 3'b000; flush_pipeline = 1'b1; flush_order = 64'd10;
    step();
    flush_pipeline = 1'b0;
    chk("squash_busy", 64'(busy), 64'd1);
    chk("squash_addr_held", 64'(dmem_addr), 64'h1000);
    dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_resp = 1'b0;
    chk("squash_resp_valid", 64'(resp_valid), 64'd0);
    chk("squash_idle", 64'(busy), 64'd0);
    req_order[63:0] = 64'd30;
    $display("sequence spec squash done");

    // Flush coincident with dmem_resp: back to IDLE with no response.
    do_reset();
    req_valid = 3'b010;
    step();
    req_valid = 3'b000; flush_pipeline = 1'b1; flush_order = 64'd10; dmem_resp = 1'b1;
    step();
    flush_pipeline = 1'b0; dmem_resp = 1'b0;
    chk("flushresp_busy", 64'(busy), 64'd0);
    chk("flushresp_resp_valid", 64'(resp_valid), 64'd0);
    $display("sequence flush with response done");

    // Store is never squashed.
    do_reset();
    req_order[191:128] = 64'd20;
    req_valid = 3'b100;
    #1 chk("store_grant", 64'(grant), 64'b100);
    step();
    req_valid = 3'b000; flush_pipeline = 1'b1; flush_order = 64'd10;
    step();
    flush_pipeline = 1'b0;
    chk("store_busy", 64'(busy), 64'd1);
    dmem_resp = 1'b1; dmem_rdata = 32'hAAAA_AAAA;
    step();
    dmem_resp = 1'b0;
    chk("store_resp_valid", 64'(resp_valid), 64'b100);
    chk("store_resp_rdata", 64'(resp_rdata), 64'd0);
    req_order[191:128] = 64'd25;
    $display("sequence store no-squash done");

    // Reset during WAIT abandons the transaction.
    do_reset();
    req_valid = 3'b010;
    step();
    req_valid = 3'b000; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwait_busy", 64'(busy), 64'd0);
    chk("rstwait_addr", 64'(dmem_addr), 64'd0);
    chk("rstwait_rmask", 64'(dmem_rmask), 64'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
    step();
    dmem_resp = 1'b0;
    chk("rstwait_resp_valid", 64'(resp_valid), 64'd0);
    chk("rstwait_resp_rdata", 64'(resp_rdata), 64'd0);
    $display("sequence reset in wait done");

    // dmem_resp while idle is ignored.
    do_reset();
    dmem_resp = 1'b1; dmem_rdata = 32'h9999_9999;
    step();
    dmem_resp = 1'b0;
    chk("idleresp_resp_valid", 64'(resp_valid), 64'd0);
    chk("idleresp_busy", 64'(busy), 64'd0);
    $display("sequence idle response done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
